// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package otter_pkg;

  // Next-PC source encoding driven by the control unit; 6 and 7 fall back to PC+4.
  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pc_src_t;

  // Fetch handshake states.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] OTTER_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC target select with trap-vector masking and misaligned-target detection.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the target is taken.
module pc_next_mux (
  input  logic [2:0]  pc_source,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] jalr,
  input  logic [31:0] branch,
  input  logic [31:0] jal,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] target,
  output logic        misaligned
);
  import otter_pkg::*;

  // Pick the target; only computed jump/branch targets can be misaligned,
  // trap addresses are word-aligned by masking. No compressed ISA, so bit 1 counts.
  always_comb begin
    target     = pc_plus4;
    misaligned = 1'b0;
    case (pc_src_t'(pc_source))
      PC_JALR: begin
        target     = jalr;
        misaligned = |jalr[1:0];
      end
      PC_BRANCH: begin
        target     = branch;
        misaligned = |branch[1:0];
      end
      PC_JAL: begin
        target     = jal;
        misaligned = |jal[1:0];
      end
      PC_MTVEC: target = {mtvec[31:2], 2'b00};
      PC_MEPC:  target = {mepc[31:2], 2'b00};
      default:  target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, next-PC selection and instruction-fetch handshake; holds IR for the control unit.
// Latency: IR/IR_VALID update the cycle after IMEM_ACK; PC updates the cycle after PC_WRITE.
// Backpressure: one outstanding fetch; IR held until PC_WRITE; a redirect mid-fetch drains the stale ACK.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC = otter_pkg::OTTER_RESET_VEC
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_WRITE,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JALR,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JAL,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_RDEN,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] IR,
  output logic        IR_VALID,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        MISALIGN,
  output logic [31:0] MISALIGN_ADDR
);
  import otter_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic         misalign_q;
  logic [31:0]  misalign_addr_q;
  logic [31:0]  pc_plus4_w;
  logic [31:0]  target;
  logic         target_bad;

  assign pc_plus4_w = pc_q + 32'd4;

  pc_next_mux u_next (
    .pc_source  (PC_SOURCE),
    .pc_plus4   (pc_plus4_w),
    .jalr       (JALR),
    .branch     (BRANCH),
    .jal        (JAL),
    .mtvec      (MTVEC),
    .mepc       (MEPC),
    .target     (target),
    .misaligned (target_bad)
  );

  // PC update, IR capture, misalign reporting and handshake state.
  // A PC_WRITE always wins over a coinciding ACK: the fetched word belongs to the old PC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= FETCH;
      pc_q            <= RESET_VEC;
      ir_q            <= 32'h0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'h0;
    end else begin
      misalign_q <= 1'b0;
      if (PC_WRITE) begin
        if (target_bad) begin
          misalign_q      <= 1'b1;
          misalign_addr_q <= target;
        end else begin
          pc_q <= target;
        end
      end
      case (state)
        FETCH: begin
          if (PC_WRITE) begin
            // With ACK the request is already retired, so refetch directly;
            // otherwise the in-flight response must be drained first.
            state <= IMEM_ACK ? FETCH : DRAIN;
          end else if (IMEM_ACK) begin
            ir_q  <= IMEM_DATA;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (PC_WRITE && !target_bad) state <= FETCH;
        end
        DRAIN: begin
          if (IMEM_ACK) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign IMEM_ADDR     = pc_q;
  assign IMEM_RDEN     = (state == FETCH);
  assign IR            = ir_q;
  assign IR_VALID      = (state == HOLD);
  assign PC            = pc_q;
  assign PC_PLUS4      = pc_plus4_w;
  assign MISALIGN      = misalign_q;
  assign MISALIGN_ADDR = misalign_addr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with hand-computed expectations.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: instruction memory is emulated by driving IMEM_ACK from the tasks.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PC_WRITE = 1'b0;
  logic [2:0]  PC_SOURCE = 3'd0;
  logic [31:0] JALR = 32'h0, BRANCH = 32'h0, JAL = 32'h0, MTVEC = 32'h0, MEPC = 32'h0;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RDEN;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_DATA = 32'h0;
  logic [31:0] IR;
  logic        IR_VALID;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        MISALIGN;
  logic [31:0] MISALIGN_ADDR;

  int vectors = 0;
  int miscompares = 0;

  pc_fetch_unit #(.RESET_VEC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .PC_WRITE(PC_WRITE), .PC_SOURCE(PC_SOURCE),
    .JALR(JALR), .BRANCH(BRANCH), .JAL(JAL), .MTVEC(MTVEC), .MEPC(MEPC),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_RDEN(IMEM_RDEN), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .IR(IR), .IR_VALID(IR_VALID), .PC(PC), .PC_PLUS4(PC_PLUS4),
    .MISALIGN(MISALIGN), .MISALIGN_ADDR(MISALIGN_ADDR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle memory response, arriving one cycle after the request cycle.
  task automatic do_fetch(input logic [31:0] d);
    tick();
    IMEM_ACK = 1'b1; IMEM_DATA = d;
    tick();
    IMEM_ACK = 1'b0; IMEM_DATA = 32'h0;
  endtask

  task automatic pc_write(input logic [2:0] src);
    PC_WRITE = 1'b1; PC_SOURCE = src;
    tick();
    PC_WRITE = 1'b0; PC_SOURCE = 3'd0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
    vectors++; if (IMEM_ADDR !== 32'h0) begin miscompares++; $display("FAIL reset_addr got=%h exp=%h", IMEM_ADDR, 32'h0); end
    vectors++; if (IMEM_RDEN !== 1'b1) begin miscompares++; $display("FAIL reset_rden got=%b exp=1", IMEM_RDEN); end
    vectors++; if (IR_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_irv got=%b exp=0", IR_VALID); end
    vectors++; if (IR !== 32'h0) begin miscompares++; $display("FAIL reset_ir got=%h exp=0", IR); end
    vectors++; if (MISALIGN !== 1'b0 || MISALIGN_ADDR !== 32'h0) begin miscompares++; $display("FAIL reset_mis got=%b/%h exp=0/0", MISALIGN, MISALIGN_ADDR); end
    // Response two cycles after the request.
    tick(); tick();
    IMEM_ACK = 1'b1; IMEM_DATA = 32'h0000_0013;
    vectors++; if (IR_VALID !== 1'b0) begin miscompares++; $display("FAIL rv_early_irv got=%b exp=0", IR_VALID); end
    tick();
    IMEM_ACK = 1'b0; IMEM_DATA = 32'h0;
    vectors++; if (IR !== 32'h13 || IR_VALID !== 1'b1) begin miscompares++; $display("FAIL rv_ir got=%h/%b exp=00000013/1", IR, IR_VALID); end
    vectors++; if (PC_PLUS4 !== 32'h4) begin miscompares++; $display("FAIL rv_plus4 got=%h exp=4", PC_PLUS4); end
    vectors++; if (IMEM_RDEN !== 1'b0) begin miscompares++; $display("FAIL rv_hold_rden got=%b exp=0", IMEM_RDEN); end
  endtask

  task automatic test_seq_wrap();
    JAL = 32'hFFFF_FFFC;
    pc_write(3'd3);
    vectors++; if (PC !== 32'hFFFF_FFFC || PC_PLUS4 !== 32'h0) begin miscompares++; $display("FAIL wrap_setup got=%h/%h exp=fffffffc/0", PC, PC_PLUS4); end
    do_fetch(32'h0000_0001);
    pc_write(3'd0);
    vectors++; if (PC !== 32'h0 || IMEM_ADDR !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got=%h/%h exp=0/0", PC, IMEM_ADDR); end
    vectors++; if (IR_VALID !== 1'b0 || IMEM_RDEN !== 1'b1) begin miscompares++; $display("FAIL wrap_fetch got=irv %b rden %b exp=0/1", IR_VALID, IMEM_RDEN); end
    do_fetch(32'h0000_0002);
  endtask

  task automatic test_branch_jalr();
    BRANCH = 32'h0000_0100;
    pc_write(3'd2);
    vectors++; if (PC !== 32'h100) begin miscompares++; $display("FAIL branch_pc got=%h exp=100", PC); end
    do_fetch(32'h0000_0003);
    JALR = 32'h0000_0206;
    pc_write(3'd1);
    vectors++; if (MISALIGN !== 1'b1 || MISALIGN_ADDR !== 32'h206) begin miscompares++; $display("FAIL jalr_mis got=%b/%h exp=1/206", MISALIGN, MISALIGN_ADDR); end
    vectors++; if (PC !== 32'h100 || IR_VALID !== 1'b1) begin miscompares++; $display("FAIL jalr_hold got=%h/%b exp=100/1", PC, IR_VALID); end
    tick();
    vectors++; if (MISALIGN !== 1'b0 || MISALIGN_ADDR !== 32'h206) begin miscompares++; $display("FAIL jalr_pulse got=%b/%h exp=0/206", MISALIGN, MISALIGN_ADDR); end
  endtask

  task automatic test_trap();
    MTVEC = 32'h0000_0803;
    pc_write(3'd4);
    vectors++; if (PC !== 32'h800 || MISALIGN !== 1'b0) begin miscompares++; $display("FAIL mtvec_pc got=%h/%b exp=800/0", PC, MISALIGN); end
    do_fetch(32'h0000_0004);
    MEPC = 32'h0000_0124;
    pc_write(3'd5);
    vectors++; if (PC !== 32'h124) begin miscompares++; $display("FAIL mepc_pc got=%h exp=124", PC); end
    do_fetch(32'h0000_0005);
    pc_write(3'd6);
    vectors++; if (PC !== 32'h128) begin miscompares++; $display("FAIL src6_pc got=%h exp=128", PC); end
    do_fetch(32'h0000_0006);
  endtask

  task automatic test_redirect();
    logic [31:0] ir_old;
    // Redirect while the request is in flight.
    JAL = 32'h0000_0040;
    pc_write(3'd3);
    ir_old = IR;
    JAL = 32'h0000_0080;
    pc_write(3'd3);
    vectors++; if (IMEM_RDEN !== 1'b0 || IR_VALID !== 1'b0 || PC !== 32'h80) begin miscompares++; $display("FAIL drain_enter got=rden %b irv %b pc %h exp=0/0/80", IMEM_RDEN, IR_VALID, PC); end
    tick();
    IMEM_ACK = 1'b1; IMEM_DATA = 32'hDEAD_BEEF;
    tick();
    IMEM_ACK = 1'b0; IMEM_DATA = 32'h0;
    vectors++; if (IMEM_RDEN !== 1'b1 || IMEM_ADDR !== 32'h80) begin miscompares++; $display("FAIL drain_exit got=%b/%h exp=1/80", IMEM_RDEN, IMEM_ADDR); end
    vectors++; if (IR !== ir_old) begin miscompares++; $display("FAIL drain_ir got=%h exp=%h", IR, ir_old); end
    do_fetch(32'h0000_0011);
    vectors++; if (IR !== 32'h11 || IR_VALID !== 1'b1) begin miscompares++; $display("FAIL refetch_ir got=%h/%b exp=11/1", IR, IR_VALID); end
    // Redirect coinciding with the ACK.
    JAL = 32'h0000_0040;
    pc_write(3'd3);
    tick();
    JAL = 32'h0000_0080;
    IMEM_ACK = 1'b1; IMEM_DATA = 32'h0000_CAFE;
    pc_write(3'd3);
    IMEM_ACK = 1'b0; IMEM_DATA = 32'h0;
    vectors++; if (IMEM_RDEN !== 1'b1 || IMEM_ADDR !== 32'h80 || IR_VALID !== 1'b0) begin miscompares++; $display("FAIL coinc got=rden %b addr %h irv %b exp=1/80/0", IMEM_RDEN, IMEM_ADDR, IR_VALID); end
    vectors++; if (IR !== 32'h11) begin miscompares++; $display("FAIL coinc_ir got=%h exp=11", IR); end
    do_fetch(32'h0000_0022);
    vectors++; if (IR !== 32'h22) begin miscompares++; $display("FAIL coinc_refetch got=%h exp=22", IR); end
  endtask

  task automatic test_reset_mid();
    JAL = 32'h0000_0040;
    pc_write(3'd3);
    JAL = 32'h0000_0080;
    pc_write(3'd3);
    vectors++; if (IMEM_RDEN !== 1'b0) begin miscompares++; $display("FAIL rmid_drain got=%b exp=0", IMEM_RDEN); end
    #2;
    RST = 1'b1;
    #1;
    vectors++; if (PC !== 32'h0 || IMEM_RDEN !== 1'b1 || IR !== 32'h0) begin miscompares++; $display("FAIL rmid_async got=pc %h rden %b ir %h exp=0/1/0", PC, IMEM_RDEN, IR); end
    vectors++; if (IR_VALID !== 1'b0 || MISALIGN_ADDR !== 32'h0) begin miscompares++; $display("FAIL rmid_regs got=%b/%h exp=0/0", IR_VALID, MISALIGN_ADDR); end
    tick();
    RST = 1'b0;
    do_fetch(32'h0000_0013);
    vectors++; if (IR !== 32'h13 || PC !== 32'h0 || IR_VALID !== 1'b1) begin miscompares++; $display("FAIL rmid_restart got=%h/%h/%b exp=13/0/1", IR, PC, IR_VALID); end
  endtask

  initial begin
    test_reset();
    test_seq_wrap();
    test_branch_jalr();
    test_trap();
    test_redirect();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter register, next-PC selection and instruction-fetch handshake for the OTTER core.
- Consumes the JALR/BRANCH/JAL targets from the branch address generator, plus MTVEC/MEPC from the CSR file.
- Fetches from instruction memory, holds the instruction register (IR) for the control unit, and flags misaligned control-transfer targets.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- PC_WRITE  in  1  control-unit request to advance/redirect the PC this cycle.
- PC_SOURCE  in  3  0=PC+4, 1=JALR, 2=BRANCH, 3=JAL, 4=MTVEC, 5=MEPC; 6,7 treated as 0.
- JALR  in  32  jalr target.
- BRANCH  in  32  branch target.
- JAL  in  32  jal target.
- MTVEC  in  32  trap vector.
- MEPC  in  32  trap return address.
- IMEM_ADDR  out  32  fetch address; equals PC.
- IMEM_RDEN  out  1  fetch request.
- IMEM_ACK  in  1  one-cycle response strobe.
- IMEM_DATA  in  32  instruction word, valid with IMEM_ACK.
- IR  out  32  captured instruction.
- IR_VALID  out  1  IR holds the instruction at PC.
- PC  out  32  current PC.
- PC_PLUS4  out  32  PC+4, for the rd link value.
- MISALIGN  out  1  one-cycle pulse: rejected misaligned target.
- MISALIGN_ADDR  out  32  offending target; held until the next MISALIGN.

Behaviour:
- Reset (asynchronous, any state):
  - PC=RESET_VEC, IR=0, IR_VALID=0, MISALIGN=0, MISALIGN_ADDR=0, state=FETCH.
  - Instruction memory shares RST, so no pre-reset ACK can arrive.
- Next-PC computation (combinational):
  - Select the target by PC_SOURCE.
  - PC+4 wraps modulo 2^32.
  - MTVEC and MEPC targets have bits [1:0] forced to 0.
  - A JALR, BRANCH or JAL target with bits[1:0]!=0 is misaligned. Bit 1 matters; there is no compressed-instruction support.
- FSM states: FETCH, HOLD, DRAIN.
- FETCH:
  - IMEM_RDEN=1; IMEM_ADDR=PC stable; IR_VALID=0.
  - Memory samples the address on the first RDEN cycle. ACK arrives at least 1 cycle later, exactly once per request.
  - IMEM_ACK and no PC_WRITE: IR<=IMEM_DATA, IR_VALID<=1, go to HOLD. Fetch latency is ACK cycle +1.
  - PC_WRITE and no ACK (redirect, e.g. interrupt): PC<=next and go to DRAIN. Misalignment checks apply as in HOLD; on a rejected target go to DRAIN with PC unchanged.
  - PC_WRITE and ACK in the same cycle: discard the data, apply the PC update, stay in FETCH, issue the new request next cycle.
- HOLD:
  - IMEM_RDEN=0; IR_VALID=1; IR stable.
  - PC_WRITE with an aligned target: PC<=next, IR_VALID<=0, go to FETCH.
  - PC_WRITE with a misaligned target: PC unchanged, MISALIGN pulses 1 cycle, MISALIGN_ADDR<=target, stay in HOLD. The control unit follows with PC_WRITE, PC_SOURCE=MTVEC.
  - No PC_WRITE: hold indefinitely.
- DRAIN:
  - IMEM_RDEN=0; IR_VALID=0.
  - On IMEM_ACK the data is discarded and the block goes to FETCH.
  - PC_WRITE in DRAIN updates PC (same alignment rules) and the block stays in DRAIN until ACK.
- PC_PLUS4 is always PC+4 and is combinational from the PC register.
- MISALIGN is registered, asserted the cycle after the rejected PC_WRITE.
- IR changes only on an accepted ACK.

Decomposition:
- Package otter_pkg:
  - pc_src_t enum (PC_PLUS4, PC_JALR, PC_BRANCH, PC_JAL, PC_MTVEC, PC_MEPC).
  - fetch_state_t enum (FETCH, HOLD, DRAIN).
  - Default RESET_VEC constant.
- Sub-module pc_next_mux: combinational target select, MTVEC/MEPC masking and misalign flag. It is instantiated once.

Test Plan:
- Reset vector fetch:
  - Stimulus: RST pulse, RESET_VEC=0, memory ACKs 2 cycles after RDEN with 32'h0000_0013.
  - Required: IMEM_ADDR=0, RDEN=1 out of reset; IR=32'h13, IR_VALID=1 the cycle after ACK; PC_PLUS4=4.
- Sequential advance:
  - Stimulus: in HOLD at PC=0xFFFF_FFFC, PC_WRITE with source 0.
  - Required: PC=0x0000_0000 (wrap), IR_VALID=0, new fetch at address 0.
- Taken branch and jalr:
  - Stimulus: BRANCH=0x0000_0100, source 2.
  - Required: PC=0x100.
  - Stimulus: JALR=0x0000_0206, source 1.
  - Required: MISALIGN pulse, MISALIGN_ADDR=0x206, PC stays 0x100, IR_VALID stays 1.
- Trap vector masking:
  - Stimulus: MTVEC=0x0000_0803, source 4.
  - Required: PC=0x800.
  - Stimulus: MEPC=0x0000_0124, source 5.
  - Required: PC=0x124.
- Redirect mid-fetch:
  - Stimulus: in FETCH at PC=0x40, PC_WRITE with JAL=0x80 two cycles before ACK.
  - Required: DRAIN; the ACK data is not loaded into IR; then FETCH at 0x80.
  - Stimulus: same, but PC_WRITE coincides with ACK.
  - Required: data discarded, next RDEN at 0x80, no DRAIN.
- Reset mid-operation:
  - Stimulus: assert RST asynchronously in DRAIN.
  - Required: outputs at reset values immediately, before the next clock edge; fetch restarts at RESET_VEC.
